// File: rtl/vga_rect_scheduler.sv
// Round-robin scheduler that shares one VGA pixel-plot port between NREQ
// rectangle-fill requesters, scanning each granted rectangle one pixel per clock.
module vga_rect_scheduler #(
   parameter int NREQ  = 3,
   parameter int SCR_W = 160,
   parameter int SCR_H = 120
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_x,
   input  logic [7*NREQ-1:0] req_y,
   input  logic [8*NREQ-1:0] req_w,
   input  logic [7*NREQ-1:0] req_h,
   input  logic [3*NREQ-1:0] req_color,
   output logic [NREQ-1:0]   done,
   output logic [7:0]        VGA_X,
   output logic [6:0]        VGA_Y,
   output logic [2:0]        VGA_COLOR,
   output logic              plot,
   output logic              busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = IW + 1;

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   state_t state, state_nxt;

   logic [IW-1:0] last, owner, gnt_idx;
   logic [CW-1:0] cand;
   logic          gnt_any;

   logic [7:0] x0, w, cx, nx;
   logic [6:0] y0, h, cy, ny;
   logic [2:0] color;

   logic [7:0] sel_x, sel_w;
   logic [6:0] sel_y, sel_h;
   logic [2:0] sel_color;

   logic       row_end, last_pix, pix_on;
   logic [8:0] px_sum;
   logic [7:0] py_sum;

   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_color;
   logic       plot_r;

   // Round-robin search: the lowest offset from last+1 that is valid wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = {1'b0, last} + CW'(k);
         if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
         if (req_valid[cand[IW-1:0]]) begin
            gnt_idx = cand[IW-1:0];
            gnt_any = 1'b1;
         end
      end
   end

   assign sel_x     = req_x[8*gnt_idx +: 8];
   assign sel_y     = req_y[7*gnt_idx +: 7];
   assign sel_w     = req_w[8*gnt_idx +: 8];
   assign sel_h     = req_h[7*gnt_idx +: 7];
   assign sel_color = req_color[3*gnt_idx +: 3];

   // The output registers always hold the pixel being shown; this computes the
   // one to load next (first pixel at grant, successor while drawing).
   always_comb begin
      row_end  = (cx == w - 8'd1);
      last_pix = row_end && (cy == h - 7'd1);
      nx       = row_end ? 8'd0 : cx + 8'd1;
      ny       = row_end ? cy + 7'd1 : cy;
      if (state == S_IDLE) begin
         px_sum = {1'b0, sel_x};
         py_sum = {1'b0, sel_y};
      end else begin
         px_sum = {1'b0, x0} + {1'b0, nx};
         py_sum = {1'b0, y0} + {1'b0, ny};
      end
      pix_on = (px_sum < 9'(SCR_W)) && (py_sum < 8'(SCR_H));
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (gnt_any) state_nxt = (sel_w == 8'd0 || sel_h == 7'd0) ? S_DONE : S_DRAW;
         S_DRAW: if (last_pix) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         x0        <= '0;
         y0        <= '0;
         w         <= '0;
         h         <= '0;
         color     <= '0;
         cx        <= '0;
         cy        <= '0;
         owner     <= '0;
         last      <= IW'(NREQ - 1);
         vga_x     <= '0;
         vga_y     <= '0;
         vga_color <= '0;
         plot_r    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (gnt_any) begin
               x0        <= sel_x;
               y0        <= sel_y;
               w         <= sel_w;
               h         <= sel_h;
               color     <= sel_color;
               owner     <= gnt_idx;
               last      <= gnt_idx;
               cx        <= '0;
               cy        <= '0;
               vga_x     <= sel_x;
               vga_y     <= sel_y;
               vga_color <= sel_color;
               plot_r    <= pix_on && (sel_w != 8'd0) && (sel_h != 7'd0);
            end
            S_DRAW: begin
               if (last_pix) begin
                  plot_r <= 1'b0;
               end else begin
                  cx     <= nx;
                  cy     <= ny;
                  vga_x  <= px_sum[7:0];
                  vga_y  <= py_sum[6:0];
                  plot_r <= pix_on;
               end
            end
            default: plot_r <= 1'b0;
         endcase
      end
   end

   // Ready is gated by resetn so nothing is offered while reset is held.
   always_comb begin
      req_ready = '0;
      done      = '0;
      busy      = (state != S_IDLE);
      if (state == S_IDLE && gnt_any && resetn) req_ready[gnt_idx] = 1'b1;
      if (state == S_DONE) done[owner] = 1'b1;
   end

   assign VGA_X     = vga_x;
   assign VGA_Y     = vga_y;
   assign VGA_COLOR = vga_color;
   assign plot      = plot_r;

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// Scoreboard bench for vga_rect_scheduler: a transaction-level model predicts
// grants, plotted pixels and done pulses with their cycle numbers.
module tb_vga_rect_scheduler;

   localparam int NREQ = 3;

   typedef struct {
      int x; int y; int w; int h; int c;
   } cmd_t;

   typedef struct {
      int kind; int idx; int x; int y; int c; int cyc;
   } ev_t;

   logic              CLOCK_50 = 1'b0;
   logic              resetn   = 1'b0;
   logic [NREQ-1:0]   req_valid, req_ready, done;
   logic [8*NREQ-1:0] req_x, req_w;
   logic [7*NREQ-1:0] req_y, req_h;
   logic [3*NREQ-1:0] req_color;
   logic [7:0]        VGA_X;
   logic [6:0]        VGA_Y;
   logic [2:0]        VGA_COLOR;
   logic              plot, busy;

   vga_rect_scheduler #(.NREQ(NREQ), .SCR_W(160), .SCR_H(120)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
      .req_color(req_color), .done(done),
      .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR),
      .plot(plot), .busy(busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_pass   = 0;
   bit   pend[NREQ];
   cmd_t cmd[NREQ];
   int   m_last  = NREQ - 1;
   int   m_free  = 0;
   int   m_grant = -1;
   ev_t  exp_q[$];
   int   dut_grants[$];

   task automatic check(input string name, input bit ok, input string act, input string exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %s, expected %s", name, act, exp);
   endtask

   function automatic ev_t mk(int kind, int idx, int x, int y, int c, int cy);
      ev_t e;
      e.kind = kind; e.idx = idx; e.x = x; e.y = y; e.c = c; e.cyc = cy;
      return e;
   endfunction

   function automatic cmd_t mkc(int x, int y, int w, int h, int c);
      cmd_t r;
      r.x = x; r.y = y; r.w = w; r.h = h; r.c = c;
      return r;
   endfunction

   function automatic string fmt(ev_t e);
      string k;
      k = (e.kind == 0) ? "grant" : (e.kind == 1) ? "pixel" : "done";
      return $sformatf("%s req%0d (%0d,%0d) col%0d @cyc%0d", k, e.idx, e.x, e.y, e.c, e.cyc);
   endfunction

   function automatic int oh_idx(logic [NREQ-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic bit any_pend();
      for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic string qstr();
      string s = "";
      foreach (dut_grants[i]) s = {s, $sformatf("%0d ", dut_grants[i])};
      return s;
   endfunction

   function automatic cmd_t rand_cmd();
      int x, y;
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(112, 127)) : int'($urandom_range(0, 119));
      return mkc(x, y, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
   endfunction

   task automatic apply_inputs();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]         = pend[i];
         req_x[8*i +: 8]      = 8'(cmd[i].x);
         req_y[7*i +: 7]      = 7'(cmd[i].y);
         req_w[8*i +: 8]      = 8'(cmd[i].w);
         req_h[7*i +: 7]      = 7'(cmd[i].h);
         req_color[3*i +: 3]  = 3'(cmd[i].c);
      end
   endtask

   // Reference model: when the scheduler is free and someone is pending, pick
   // the next pending requester after the last one served and list every
   // event the rectangle produces, with the cycle in which it must appear.
   task automatic model_eval();
      int g = -1;
      cmd_t m;
      if (!resetn || cyc < m_free) return;
      for (int k = 1; k <= NREQ; k++) begin
         int i = (m_last + k) % NREQ;
         if (g < 0 && pend[i]) g = i;
      end
      if (g < 0) return;
      m = cmd[g];
      exp_q.push_back(mk(0, g, 0, 0, 0, cyc));
      for (int r = 0; r < m.h; r++)
         for (int col = 0; col < m.w; col++)
            if (m.x + col < 160 && m.y + r < 120)
               exp_q.push_back(mk(1, -1, m.x + col, m.y + r, m.c, cyc + 1 + r * m.w + col));
      exp_q.push_back(mk(2, g, 0, 0, 0, cyc + 1 + m.w * m.h));
      m_last  = g;
      m_grant = cyc;
      m_free  = cyc + m.w * m.h + 2;
      pend[g] = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
      apply_inputs();
      model_eval();
   endtask

   task automatic reset_assert();
      resetn = 1'b0;
      exp_q.delete();
      m_last  = NREQ - 1;
      m_free  = 0;
      m_grant = -1;
   endtask

   task automatic reset_release();
      tick();
      tick();
      @(posedge CLOCK_50);
      #1;
      resetn = 1'b1;
      apply_inputs();
      model_eval();
   endtask

   task automatic run_until_idle(input string name, input int budget);
      int n = 0;
      while (any_pend() || cyc < m_free + 1) begin
         if (n >= budget) begin
            check({name, "_timeout"}, 1'b0, "still busy", "idle");
            break;
         end
         tick();
         n++;
      end
   endtask

   task automatic score(input ev_t a);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event", 1'b0, fmt(a), "no event");
         return;
      end
      e = exp_q.pop_front();
      check(e.kind == 0 ? "grant" : e.kind == 1 ? "pixel" : "done",
            a.kind == e.kind && a.idx == e.idx && a.x == e.x && a.y == e.y &&
            a.c == e.c && a.cyc == e.cyc, fmt(a), fmt(e));
   endtask

   always @(negedge CLOCK_50) begin : monitor
      bit exp_busy;
      exp_busy = (cyc > m_grant) && (cyc < m_free);
      check("busy", busy === exp_busy, $sformatf("%0b", busy), $sformatf("%0b", exp_busy));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         check("missed_event", 1'b0, "nothing", fmt(exp_q[0]));
         void'(exp_q.pop_front());
      end
      if (req_ready !== '0) begin
         dut_grants.push_back(oh_idx(req_ready));
         score(mk(0, oh_idx(req_ready), 0, 0, 0, cyc));
      end
      if (plot !== 1'b0) score(mk(1, -1, int'(VGA_X), int'(VGA_Y), int'(VGA_COLOR), cyc));
      if (done !== '0) score(mk(2, oh_idx(done), 0, 0, 0, cyc));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int   n, gc, g_first, prev, arm0;
      int   rearm[NREQ];

      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0;
         cmd[i]  = mkc(0, 0, 0, 0, 0);
      end
      pend[1] = 1'b1;
      cmd[1]  = mkc(7, 7, 2, 2, 4);
      apply_inputs();
      repeat (2) @(posedge CLOCK_50);
      #1;
      check("rst_ready", req_ready === '0, $sformatf("%b", req_ready), "0");
      check("rst_done",  done === '0,      $sformatf("%b", done), "0");
      check("rst_plot",  plot === 1'b0,    $sformatf("%b", plot), "0");
      check("rst_xy",    VGA_X === 8'd0 && VGA_Y === 7'd0,
            $sformatf("(%0d,%0d)", VGA_X, VGA_Y), "(0,0)");
      check("rst_color", VGA_COLOR === 3'd0, $sformatf("%0d", VGA_COLOR), "0");
      check("rst_busy",  busy === 1'b0,    $sformatf("%b", busy), "0");
      pend[1] = 1'b0;
      apply_inputs();
      reset_release();

      // Single 3x2 rectangle from requester 0.
      dut_grants.delete();
      pend[0] = 1'b1;
      cmd[0]  = mkc(10, 20, 3, 2, 5);
      run_until_idle("basic", 100);
      check("basic_grant", dut_grants.size() == 1 && dut_grants[0] == 0, qstr(), "0");

      // Three requesters at once, re-requesting once after each service.
      reset_assert();
      reset_release();
      dut_grants.delete();
      for (int i = 0; i < NREQ; i++) begin
         pend[i]  = 1'b1;
         cmd[i]   = mkc(40 + i, 50 + i, 1, 1, i + 1);
         rearm[i] = 1;
      end
      n = 0;
      while ((any_pend() || rearm[0] + rearm[1] + rearm[2] > 0 || cyc < m_free + 1) && n < 200) begin
         tick();
         n++;
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && rearm[i] > 0) begin
               pend[i] = 1'b1;
               cmd[i]  = mkc(60 + i, 70 + i, 1, 1, 7 - i);
               rearm[i]--;
            end
      end
      check("rr_budget", n < 200, $sformatf("%0d cycles", n), "<200");
      check("rr_order", dut_grants.size() == 6 && dut_grants[0] == 0 && dut_grants[1] == 1 &&
            dut_grants[2] == 2 && dut_grants[3] == 0 && dut_grants[4] == 1 && dut_grants[5] == 2,
            qstr(), "0 1 2 0 1 2");

      // Zero-size rectangles.
      pend[1] = 1'b1;
      cmd[1]  = mkc(5, 5, 0, 5, 3);
      run_until_idle("zero_w", 20);
      pend[1] = 1'b1;
      cmd[1]  = mkc(5, 5, 4, 0, 3);
      run_until_idle("zero_h", 20);

      // Clipping at the bottom-right corner.
      pend[2] = 1'b1;
      cmd[2]  = mkc(158, 119, 4, 2, 6);
      run_until_idle("clip", 40);

      // Reset in the middle of a 10x10 rectangle, at draw pixel 37.
      prev    = m_grant;
      pend[0] = 1'b1;
      cmd[0]  = mkc(20, 30, 10, 10, 2);
      n = 0;
      while (m_grant == prev && n < 50) begin tick(); n++; end
      gc = m_grant;
      while (cyc < gc + 38 && n < 150) begin tick(); n++; end
      check("middraw_reached", cyc == gc + 38, $sformatf("cyc %0d", cyc), $sformatf("cyc %0d", gc + 38));
      pend[0] = 1'b1;
      cmd[0]  = mkc(5, 5, 1, 1, 2);
      pend[2] = 1'b1;
      cmd[2]  = mkc(50, 60, 1, 1, 6);
      apply_inputs();
      reset_assert();
      #1;
      check("middraw_plot",  plot === 1'b0,   $sformatf("%b", plot), "0");
      check("middraw_ready", req_ready === '0, $sformatf("%b", req_ready), "0");
      check("middraw_done",  done === '0,      $sformatf("%b", done), "0");
      dut_grants.delete();
      reset_release();
      run_until_idle("after_reset", 40);
      check("after_reset_order", dut_grants.size() == 2 && dut_grants[0] == 0 && dut_grants[1] == 2,
            qstr(), "0 2");

      // Requester 0 continuously valid; requester 2 arrives mid-draw.
      dut_grants.delete();
      prev    = m_grant;
      g_first = -1;
      arm0    = 2;
      pend[0] = 1'b1;
      cmd[0]  = mkc(30, 40, 2, 2, 1);
      n = 0;
      while ((any_pend() || arm0 > 0 || cyc < m_free + 1) && n < 300) begin
         tick();
         n++;
         if (g_first < 0 && m_grant != prev) g_first = m_grant;
         if (!pend[0] && arm0 > 0) begin
            pend[0] = 1'b1;
            cmd[0]  = mkc(32, 42, 2, 2, 1);
            arm0--;
         end
         if (g_first >= 0 && cyc == g_first + 2) begin
            pend[2] = 1'b1;
            cmd[2]  = mkc(100, 100, 2, 2, 4);
         end
      end
      check("fair_order", dut_grants.size() >= 3 && dut_grants[0] == 0 && dut_grants[1] == 2 &&
            dut_grants[2] == 0, qstr(), "0 2 0 ...");

      // Random traffic against the model.
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               cmd[i]  = rand_cmd();
            end
         tick();
      end
      run_until_idle("random_drain", 2000);
      tick();
      check("queue_empty", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
